// File: rtl/tl_ul_client_arbiter_if.sv
// TileLink-UL A/D channel bundle. The master modport is the requester side;
// the slave modport is the responder side.
interface tl_ul_if #(
    parameter int unsigned SRC_W  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [2:0]            a_param;
    logic [2:0]            a_size;
    logic [SRC_W-1:0]      a_source;
    logic [ADDR_W-1:0]     a_address;
    logic [DATA_W/8-1:0]   a_mask;
    logic [DATA_W-1:0]     a_data;

    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [1:0]            d_param;
    logic [2:0]            d_size;
    logic [SRC_W-1:0]      d_source;
    logic                  d_denied;
    logic                  d_corrupt;
    logic [DATA_W-1:0]     d_data;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data,
        input  d_ready
    );
endinterface

// File: rtl/tl_ul_client_arbiter.sv
// Two-client TileLink-UL arbiter: round-robin A grant locked across Put bursts,
// client index prepended to the source, D routed back by that bit, per-client in-flight cap.
module tl_ul_client_arbiter #(
    parameter int unsigned SRC_W        = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_SIZE     = 6,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic   clock,
    input  logic   reset,
    tl_ul_if.slave  c0,
    tl_ul_if.slave  c1,
    tl_ul_if.master m
);
    localparam int unsigned BEAT_LG = $clog2(DATA_W / 8);
    localparam int unsigned CNT_W   = 9;

    if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 15) begin : g_bad_inflight
        $error("MAX_INFLIGHT must be in 1..15");
    end
    if (MAX_SIZE > 7) begin : g_bad_size
        $error("MAX_SIZE must fit the 3-bit size field");
    end

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_pri_q, rr_pri_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
    logic [3:0]       inflight0_q, inflight0_d;
    logic [3:0]       inflight1_q, inflight1_d;

    logic             elig0, elig1;
    logic             gnt_valid, gnt_idx;
    logic             a_fire, d_fire, d_sel, d_first, d_last;
    logic             inc0, inc1, dec0, dec1;
    logic [CNT_W-1:0] a_beats, d_beats;

    function automatic logic [CNT_W-1:0] beat_count(input logic [2:0] size, input logic multi);
        if (multi && size > 3'(BEAT_LG)) begin
            return CNT_W'(1) << (size - 3'(BEAT_LG));
        end
        return CNT_W'(1);
    endfunction

    // Grant is combinational so an eligible request passes with no added latency.
    always_comb begin
        elig0     = c0.a_valid && (inflight0_q < 4'(MAX_INFLIGHT));
        elig1     = c1.a_valid && (inflight1_q < 4'(MAX_INFLIGHT));
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (state_q == StLocked) begin
            gnt_valid = 1'b1;
            gnt_idx   = owner_q;
        end else if (elig0 && elig1) begin
            gnt_valid = 1'b1;
            gnt_idx   = rr_pri_q;
        end else if (elig0) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b0;
        end else if (elig1) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b1;
        end
    end

    always_comb begin
        m.a_valid  = 1'b0;
        c0.a_ready = 1'b0;
        c1.a_ready = 1'b0;
        if (gnt_idx) begin
            m.a_opcode  = c1.a_opcode;
            m.a_param   = c1.a_param;
            m.a_size    = c1.a_size;
            m.a_source  = {1'b1, c1.a_source};
            m.a_address = c1.a_address;
            m.a_mask    = c1.a_mask;
            m.a_data    = c1.a_data;
        end else begin
            m.a_opcode  = c0.a_opcode;
            m.a_param   = c0.a_param;
            m.a_size    = c0.a_size;
            m.a_source  = {1'b0, c0.a_source};
            m.a_address = c0.a_address;
            m.a_mask    = c0.a_mask;
            m.a_data    = c0.a_data;
        end
        if (gnt_valid) begin
            if (gnt_idx) begin
                m.a_valid  = c1.a_valid;
                c1.a_ready = m.a_ready;
            end else begin
                m.a_valid  = c0.a_valid;
                c0.a_ready = m.a_ready;
            end
        end
    end

    assign d_sel       = m.d_source[SRC_W];
    assign c0.d_valid  = m.d_valid && !d_sel;
    assign c1.d_valid  = m.d_valid && d_sel;
    assign m.d_ready   = d_sel ? c1.d_ready : c0.d_ready;

    assign c0.d_opcode  = m.d_opcode;
    assign c0.d_param   = m.d_param;
    assign c0.d_size    = m.d_size;
    assign c0.d_source  = m.d_source[SRC_W-1:0];
    assign c0.d_denied  = m.d_denied;
    assign c0.d_corrupt = m.d_corrupt;
    assign c0.d_data    = m.d_data;
    assign c1.d_opcode  = m.d_opcode;
    assign c1.d_param   = m.d_param;
    assign c1.d_size    = m.d_size;
    assign c1.d_source  = m.d_source[SRC_W-1:0];
    assign c1.d_denied  = m.d_denied;
    assign c1.d_corrupt = m.d_corrupt;
    assign c1.d_data    = m.d_data;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_pri_d    = rr_pri_q;
        remaining_d = remaining_q;
        d_cnt_d     = d_cnt_q;

        a_fire  = m.a_valid && m.a_ready;
        a_beats = beat_count(m.a_size, m.a_opcode <= 3'd1);
        if (a_fire) begin
            if (state_q == StIdle) begin
                rr_pri_d = ~gnt_idx;
                if (a_beats > CNT_W'(1)) begin
                    state_d     = StLocked;
                    owner_d     = gnt_idx;
                    remaining_d = a_beats - CNT_W'(1);
                end
            end else begin
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = StIdle;
                end
            end
        end
        // Only the first beat of a request counts against the client's budget.
        inc0 = a_fire && (state_q == StIdle) && !gnt_idx;
        inc1 = a_fire && (state_q == StIdle) && gnt_idx;

        d_fire  = m.d_valid && m.d_ready;
        d_beats = beat_count(m.d_size, m.d_opcode == 3'd1);
        d_first = (d_cnt_q == '0);
        d_last  = (d_cnt_q == CNT_W'(1)) || (d_first && d_beats == CNT_W'(1));
        if (d_fire) begin
            d_cnt_d = d_first ? d_beats - CNT_W'(1) : d_cnt_q - CNT_W'(1);
        end
        dec0 = d_fire && d_last && !d_sel;
        dec1 = d_fire && d_last && d_sel;

        inflight0_d = inflight0_q + 4'(inc0) - 4'(dec0);
        inflight1_d = inflight1_q + 4'(inc1) - 4'(dec1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            rr_pri_q    <= 1'b0;
            remaining_q <= '0;
            d_cnt_q     <= '0;
            inflight0_q <= '0;
            inflight1_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_pri_q    <= rr_pri_d;
            remaining_q <= remaining_d;
            d_cnt_q     <= d_cnt_d;
            inflight0_q <= inflight0_d;
            inflight1_q <= inflight1_d;
        end
    end
endmodule

// File: tb/tb_tl_ul_client_arbiter.sv
// Directed bench for tl_ul_client_arbiter: arbitration, burst locking, back-pressure,
// in-flight cap, D routing and mid-burst reset.
module tb_tl_ul_client_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    tl_ul_if #(.SRC_W(2), .ADDR_W(32), .DATA_W(32)) c0_if ();
    tl_ul_if #(.SRC_W(2), .ADDR_W(32), .DATA_W(32)) c1_if ();
    tl_ul_if #(.SRC_W(3), .ADDR_W(32), .DATA_W(32)) m_if ();

    tl_ul_client_arbiter #(
        .SRC_W(2), .ADDR_W(32), .DATA_W(32), .MAX_SIZE(6), .MAX_INFLIGHT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .c0(c0_if.slave),
        .c1(c1_if.slave),
        .m(m_if.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic drive_c0(input logic v, input logic [2:0] op, input logic [2:0] size,
                            input logic [1:0] src, input logic [31:0] addr,
                            input logic [31:0] data);
        c0_if.a_valid   = v;
        c0_if.a_opcode  = op;
        c0_if.a_param   = 3'd0;
        c0_if.a_size    = size;
        c0_if.a_source  = src;
        c0_if.a_address = addr;
        c0_if.a_mask    = 4'hf;
        c0_if.a_data    = data;
    endtask

    task automatic drive_c1(input logic v, input logic [2:0] op, input logic [2:0] size,
                            input logic [1:0] src, input logic [31:0] addr,
                            input logic [31:0] data);
        c1_if.a_valid   = v;
        c1_if.a_opcode  = op;
        c1_if.a_param   = 3'd0;
        c1_if.a_size    = size;
        c1_if.a_source  = src;
        c1_if.a_address = addr;
        c1_if.a_mask    = 4'hf;
        c1_if.a_data    = data;
    endtask

    task automatic drive_d(input logic v, input logic [2:0] op, input logic [2:0] size,
                           input logic [2:0] src, input logic [31:0] data);
        m_if.d_valid   = v;
        m_if.d_opcode  = op;
        m_if.d_param   = 2'd0;
        m_if.d_size    = size;
        m_if.d_source  = src;
        m_if.d_denied  = 1'b0;
        m_if.d_corrupt = 1'b0;
        m_if.d_data    = data;
    endtask

    task automatic idle_all();
        drive_c0(1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 32'h0);
        drive_c1(1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 32'h0);
        drive_d(1'b0, 3'd0, 3'd0, 3'd0, 32'h0);
        m_if.a_ready  = 1'b1;
        c0_if.d_ready = 1'b1;
        c1_if.d_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        tick();
        tick();
        settle();
        chk("rst_m_a_valid", m_if.a_valid, 1'b0);
        chk("rst_c0_a_ready", c0_if.a_ready, 1'b0);
        chk("rst_c1_d_valid", c1_if.d_valid, 1'b0);
        tick();
        reset = 1'b0;

        // Both Gets at reset exit: c0 first, then c1.
        drive_c0(1'b1, 3'd4, 3'd2, 2'b01, 32'h100, 32'h0);
        drive_c1(1'b1, 3'd4, 3'd2, 2'b10, 32'h200, 32'h0);
        settle();
        chk("t1_m_a_valid", m_if.a_valid, 1'b1);
        chk("t1_src_c0", m_if.a_source, 3'b001);
        chk("t1_c0_ready", c0_if.a_ready, 1'b1);
        chk("t1_c1_wait", c1_if.a_ready, 1'b0);
        chk("t1_addr_c0", m_if.a_address, 32'h100);
        tick();
        c0_if.a_valid = 1'b0;
        settle();
        chk("t1_src_c1", m_if.a_source, 3'b110);
        chk("t1_c1_ready", c1_if.a_ready, 1'b1);
        chk("t1_addr_c1", m_if.a_address, 32'h200);
        tick();
        c1_if.a_valid = 1'b0;

        // 4-beat PutFull from c0 holds the grant while c1 waits.
        do_reset();
        drive_c0(1'b1, 3'd0, 3'd4, 2'b00, 32'h1000, 32'hA0);
        drive_c1(1'b1, 3'd4, 3'd2, 2'b11, 32'h2000, 32'h0);
        settle();
        chk("t2_src_c0", m_if.a_source, 3'b000);
        chk("t2_data0", m_if.a_data, 32'hA0);
        chk("t2_c1_blocked0", c1_if.a_ready, 1'b0);
        for (int b = 1; b < 4; b++) begin
            tick();
            c0_if.a_data = 32'hA0 + 32'(b);
            settle();
            chk("t2_burst_data", m_if.a_data, 32'hA0 + 64'(b));
            chk("t2_c1_blocked", c1_if.a_ready, 1'b0);
        end
        tick();
        c0_if.a_valid = 1'b0;
        settle();
        chk("t2_c1_after", c1_if.a_ready, 1'b1);
        chk("t2_src_c1", m_if.a_source, 3'b111);
        tick();
        c1_if.a_valid = 1'b0;

        // Same burst with a valid gap: c1 still blocked.
        drive_c0(1'b1, 3'd0, 3'd4, 2'b00, 32'h1000, 32'hB0);
        drive_c1(1'b1, 3'd4, 3'd2, 2'b11, 32'h2000, 32'h0);
        settle();
        chk("t2g_c0_ready", c0_if.a_ready, 1'b1);
        tick();
        c0_if.a_data = 32'hB1;
        settle();
        chk("t2g_data1", m_if.a_data, 32'hB1);
        tick();
        c0_if.a_valid = 1'b0;
        settle();
        chk("t2g_gap_valid", m_if.a_valid, 1'b0);
        chk("t2g_gap_c1", c1_if.a_ready, 1'b0);
        tick();
        c0_if.a_valid = 1'b1;
        c0_if.a_data  = 32'hB2;
        settle();
        chk("t2g_data2", m_if.a_data, 32'hB2);
        chk("t2g_c1_b2", c1_if.a_ready, 1'b0);
        tick();
        c0_if.a_data = 32'hB3;
        settle();
        chk("t2g_c1_b3", c1_if.a_ready, 1'b0);
        tick();
        c0_if.a_valid = 1'b0;
        settle();
        chk("t2g_c1_after", c1_if.a_ready, 1'b1);
        tick();
        c1_if.a_valid = 1'b0;

        // Back-pressure mid-burst freezes the burst counter.
        do_reset();
        drive_c0(1'b1, 3'd0, 3'd4, 2'b01, 32'h3000, 32'hC0);
        settle();
        chk("t3_c0_ready", c0_if.a_ready, 1'b1);
        tick();
        c0_if.a_data  = 32'hC1;
        m_if.a_ready  = 1'b0;
        drive_c1(1'b1, 3'd4, 3'd2, 2'b00, 32'h3100, 32'h0);
        for (int s = 0; s < 3; s++) begin
            settle();
            chk("t3_stall_valid", m_if.a_valid, 1'b1);
            chk("t3_stall_data", m_if.a_data, 32'hC1);
            chk("t3_stall_c0", c0_if.a_ready, 1'b0);
            chk("t3_stall_c1", c1_if.a_ready, 1'b0);
            tick();
        end
        m_if.a_ready = 1'b1;
        settle();
        chk("t3_resume_data", m_if.a_data, 32'hC1);
        chk("t3_resume_c1", c1_if.a_ready, 1'b0);
        tick();
        c0_if.a_data = 32'hC2;
        settle();
        chk("t3_b2_c1", c1_if.a_ready, 1'b0);
        tick();
        c0_if.a_data = 32'hC3;
        settle();
        chk("t3_b3_c1", c1_if.a_ready, 1'b0);
        tick();
        c0_if.a_valid = 1'b0;
        settle();
        chk("t3_c1_after", c1_if.a_ready, 1'b1);
        tick();
        c1_if.a_valid = 1'b0;

        // In-flight cap: 4 Gets from c0, 5th stalls until one D returns.
        do_reset();
        drive_c0(1'b1, 3'd4, 3'd2, 2'b10, 32'h4000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t4_get_fire", c0_if.a_ready, 1'b1);
            tick();
        end
        drive_c1(1'b1, 3'd4, 3'd2, 2'b01, 32'h5000, 32'h0);
        settle();
        chk("t4_c0_capped", c0_if.a_ready, 1'b0);
        chk("t4_c1_granted", c1_if.a_ready, 1'b1);
        chk("t4_src_c1", m_if.a_source, 3'b101);
        tick();
        c1_if.a_valid = 1'b0;
        settle();
        chk("t4_c0_still", c0_if.a_ready, 1'b0);
        chk("t4_no_valid", m_if.a_valid, 1'b0);
        tick();
        drive_d(1'b1, 3'd1, 3'd2, 3'b010, 32'hD00D);
        settle();
        chk("t4_c0_d_valid", c0_if.d_valid, 1'b1);
        chk("t4_c1_d_valid", c1_if.d_valid, 1'b0);
        chk("t4_d_source", c0_if.d_source, 2'b10);
        chk("t4_d_data", c0_if.d_data, 32'hD00D);
        chk("t4_m_d_ready", m_if.d_ready, 1'b1);
        chk("t4_c0_same_cyc", c0_if.a_ready, 1'b0);
        tick();
        m_if.d_valid = 1'b0;
        settle();
        chk("t4_c0_released", c0_if.a_ready, 1'b1);
        tick();
        c0_if.a_valid = 1'b0;

        // 4-beat AccessAckData to c1: in-flight drops only on the last beat.
        do_reset();
        drive_c1(1'b1, 3'd4, 3'd2, 2'b01, 32'h6000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t5_get_fire", c1_if.a_ready, 1'b1);
            tick();
        end
        settle();
        chk("t5_c1_capped", c1_if.a_ready, 1'b0);
        tick();
        drive_d(1'b1, 3'd1, 3'd4, 3'b101, 32'hE0);
        for (int b = 0; b < 2; b++) begin
            settle();
            chk("t5_c1_d_valid", c1_if.d_valid, 1'b1);
            chk("t5_c0_d_valid", c0_if.d_valid, 1'b0);
            chk("t5_d_source", c1_if.d_source, 2'b01);
            chk("t5_m_d_ready", m_if.d_ready, 1'b1);
            chk("t5_cap_mid", c1_if.a_ready, 1'b0);
            tick();
            m_if.d_data = 32'hE1 + 32'(b);
        end
        c1_if.d_ready = 1'b0;
        settle();
        chk("t5_bp_m_d_ready", m_if.d_ready, 1'b0);
        chk("t5_bp_d_valid", c1_if.d_valid, 1'b1);
        tick();
        c1_if.d_ready = 1'b1;
        settle();
        chk("t5_cap_b3", c1_if.a_ready, 1'b0);
        tick();
        m_if.d_data = 32'hE3;
        settle();
        chk("t5_cap_b4", c1_if.a_ready, 1'b0);
        chk("t5_data_b4", c1_if.d_data, 32'hE3);
        tick();
        m_if.d_valid = 1'b0;
        settle();
        chk("t5_c1_released", c1_if.a_ready, 1'b1);
        tick();
        c1_if.a_valid = 1'b0;

        // Reset during a locked burst with two beats left.
        do_reset();
        drive_c0(1'b1, 3'd0, 3'd4, 2'b00, 32'h7000, 32'hF0);
        settle();
        chk("t6_b0", c0_if.a_ready, 1'b1);
        tick();
        c0_if.a_data = 32'hF1;
        settle();
        chk("t6_b1", c0_if.a_ready, 1'b1);
        tick();
        reset = 1'b1;
        c0_if.a_valid = 1'b0;
        drive_c1(1'b1, 3'd4, 3'd2, 2'b10, 32'h8000, 32'h0);
        tick();
        reset = 1'b0;
        settle();
        chk("t6_c1_granted", c1_if.a_ready, 1'b1);
        chk("t6_m_a_valid", m_if.a_valid, 1'b1);
        chk("t6_src_c1", m_if.a_source, 3'b110);
        tick();
        c1_if.a_valid = 1'b0;

        // Oversized request passes through unchanged.
        drive_c0(1'b1, 3'd4, 3'd7, 2'b11, 32'h9000, 32'h0);
        settle();
        chk("t7_size_pass", m_if.a_size, 3'd7);
        chk("t7_c0_ready", c0_if.a_ready, 1'b1);
        tick();
        c0_if.a_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
